nibble_serial_add_ctrl: RTL and testbench

- Multi-cycle sequencer that computes wide additions with a single 4-bit ripple-carry slice.
- Each operand pair is processed one nibble per cycle, LSB first, with the carry held in a flop between slices.
- Sits between a requester (valid/ready in) and a consumer (valid/ready out). Used where area matters more than throughput: one slice replaces WIDTH/4 slices.

---
 rtl/nibble_add_pkg.sv | 32 +++
 rtl/add_slice4.sv | 37 +++
 rtl/nibble_serial_add_ctrl.sv | 179 +++++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_add_pkg
// Description : Shared definitions for the nibble-serial adder.
//               Holds the slice width, the controller state encoding and
//               helper functions that derive the slice count and the
//               slice-counter width from the operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_add_pkg;

    // Width of the single ripple-carry slice reused on every RUN cycle.
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed to cover an operand of the given width.
    function automatic int calc_nslice(input int width);
        return width / SLICE_W;
    endfunction

    // The counter must be at least one bit wide, even for a single slice.
    function automatic int calc_cnt_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage : nibble_add_pkg
`default_nettype wire

// File: rtl/add_slice4.sv
`default_nettype none
// ============================================================================
// Module      : add_slice4
// Description : Purely combinational 4-bit ripple-carry adder slice built
//               from four full-adder cells.
// Ports       : x, y  - 4-bit addends
//               ci    - carry in
//               s     - 4-bit sum
//               co    - carry out of bit 3
// Revision    : 1.0 - initial release
// ============================================================================
module add_slice4
    import nibble_add_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    // Carry chain: w_c[0] is the slice carry-in, w_c[SLICE_W] the carry-out.
    logic [SLICE_W:0] w_c;

    assign w_c[0] = ci;

    generate
        for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fa
            assign s[gi]     = x[gi] ^ y[gi] ^ w_c[gi];
            assign w_c[gi+1] = (x[gi] & y[gi]) | (w_c[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign co = w_c[SLICE_W];

endmodule : add_slice4
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl
// Description : Multi-cycle sequencer computing WIDTH-bit additions with a
//               single 4-bit ripple-carry slice, one nibble per cycle, LSB
//               first, carry held in a flop between slices.
//               Handshake: valid/ready on both the operand and result sides.
//               Optional subtract mode enabled by the macro
//               NIBBLE_SERIAL_ADD_SUBTRACT_EN (adds input port sub).
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               in_valid, in_ready  - operand handshake (ready only in IDLE)
//               a, b, cin           - operands and carry-in
//               sub                 - subtract select (macro builds only)
//               out_valid, out_ready- result handshake
//               sum, cout           - result and carry out of the MSB
//               busy                - high while in RUN or DONE
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_ADD_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = calc_nslice(WIDTH);
    localparam int CNT_W  = calc_cnt_w(NSLICE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    generate
        if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_width_err
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic               w_sub;
    logic [SLICE_W-1:0] w_s;
    logic               w_co;
    logic [WIDTH-1:0]   w_sum_shift;

`ifdef NIBBLE_SERIAL_ADD_SUBTRACT_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // ------------------------------------------------------------------
    // The one and only adder slice
    // ------------------------------------------------------------------
    add_slice4 u_slice (
        .x  (r_a[SLICE_W-1:0]),
        .y  (r_b[SLICE_W-1:0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // Slice results enter the sum register from the MSB end, so after
    // NSLICE shifts the first (least significant) nibble lands in bits 3:0.
    generate
        if (NSLICE == 1) begin : g_sum_single
            assign w_sum_shift = w_s;
        end else begin : g_sum_multi
            assign w_sum_shift = {w_s, r_sum[WIDTH-1:SLICE_W]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1: invert B and force the carry-in.
            r_a     <= a;
            r_b     <= w_sub ? ~b : b;
            r_carry <= w_sub ? 1'b1 : cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> SLICE_W;
            r_b     <= r_b >> SLICE_W;
            r_carry <= w_co;
            r_sum   <= w_sum_shift;
            if (w_last) begin
                r_cout <= w_co;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule : nibble_serial_add_ctrl
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_add_ctrl
// Description : Self-checking bench for nibble_serial_add_ctrl (WIDTH=16).
//               Expected results come from a plain-arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NIBBLE_SERIAL_ADD_SUBTRACT_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // Reference: {cout, sum}. Subtraction yields a-b mod 2^W, cout = no borrow.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic c, input logic s);
        logic [WIDTH:0] r;
        if (s) begin
            r[WIDTH-1:0] = x - y;
            r[WIDTH]     = (x >= y);
        end else begin
            r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        end
        return r;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (sum !== '0) begin failures++; $display("FAIL reset_sum got=%h want=0000", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b want=0", cout); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle in_ready=%b busy=%b want 1/0", in_ready, busy); end
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0] va[$];
        logic [WIDTH-1:0] vb[$];
        logic             vc[$];
        logic             vs[$];
        logic [WIDTH:0]   e;
        int               cyc;
        va = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8000};
        vb = '{16'h0001, 16'h0001, 16'h0000, 16'h8000};
        vc = '{1'b0, 1'b0, 1'b1, 1'b1};
        vs = '{1'b0, 1'b0, 1'b0, 1'b0};
`ifdef NIBBLE_SERIAL_ADD_SUBTRACT_EN
        va.push_back(16'h0005); vb.push_back(16'h0007); vc.push_back(1'b1); vs.push_back(1'b1);
        va.push_back(16'h0007); vb.push_back(16'h0005); vc.push_back(1'b0); vs.push_back(1'b1);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < va.size(); i++) begin
            a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i];
            e = model(va[i], vb[i], vc[i], vs[i]);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_in_ready got=%b want=1", i, in_ready); end
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
            checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL dir%0d_busy busy=%b in_ready=%b want 1/0", i, busy, in_ready); end
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
            checks++; if (cyc != NSLICE) begin failures++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, cyc, NSLICE); end
            checks++; if (sum !== e[WIDTH-1:0]) begin failures++; $display("FAIL dir%0d_sum got=%h want=%h", i, sum, e[WIDTH-1:0]); end
            checks++; if (cout !== e[WIDTH]) begin failures++; $display("FAIL dir%0d_cout got=%b want=%b", i, cout, e[WIDTH]); end
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_return_idle in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid); end
        end
        sub = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [WIDTH:0] e;
        int             cyc;
        a = 16'hABCD; b = 16'h1234; cin = 1'b1; sub = 1'b0;
        e = model(a, b, cin, sub);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc != NSLICE) begin failures++; $display("FAIL bp_latency got=%0d want=%0d", cyc, NSLICE); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e[WIDTH-1:0] || cout !== e[WIDTH]) begin
                failures++;
                $display("FAIL bp_hold%0d out_valid=%b in_ready=%b sum=%h cout=%b want 1/0/%h/%b",
                         i, out_valid, in_ready, sum, cout, e[WIDTH-1:0], e[WIDTH]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        // out_ready high in IDLE must not start anything
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_idle_stable busy=%b out_valid=%b want 0/0", busy, out_valid); end
    endtask

    task automatic test_reset_mid_run;
        logic [WIDTH:0] e;
        int             cyc;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_ctrl out_valid=%b busy=%b want 0/0", out_valid, busy); end
        checks++; if (sum !== '0 || cout !== 1'b0) begin failures++; $display("FAIL midrst_data sum=%h cout=%b want 0000/0", sum, cout); end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_idle in_ready=%b busy=%b want 1/0", in_ready, busy); end
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b0;
        e = model(a, b, cin, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc != NSLICE) begin failures++; $display("FAIL midrst_latency got=%0d want=%0d", cyc, NSLICE); end
        checks++; if (sum !== e[WIDTH-1:0] || cout !== e[WIDTH]) begin failures++; $display("FAIL midrst_result sum=%h cout=%b want %h/%b", sum, cout, e[WIDTH-1:0], e[WIDTH]); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [WIDTH:0] e;
        int             cyc;
        int             stall;
        for (int n = 0; n < 30; n++) begin
            out_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADD_SUBTRACT_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            e = model(a, b, cin, sub);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < 50) begin
                out_ready = 1'($urandom);
                a = WIDTH'($urandom); b = WIDTH'($urandom);
                @(posedge clk); #1; cyc++;
            end
            out_ready = 1'b0;
            checks++; if (cyc != NSLICE) begin failures++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, cyc, NSLICE); end
            checks++; if (sum !== e[WIDTH-1:0] || cout !== e[WIDTH]) begin failures++; $display("FAIL rnd%0d_result sum=%h cout=%b want %h/%b", n, sum, cout, e[WIDTH-1:0], e[WIDTH]); end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                checks++; if (out_valid !== 1'b1 || sum !== e[WIDTH-1:0] || cout !== e[WIDTH]) begin failures++; $display("FAIL rnd%0d_stall out_valid=%b sum=%h cout=%b want 1/%h/%b", n, out_valid, sum, cout, e[WIDTH-1:0], e[WIDTH]); end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rnd%0d_return_idle in_ready=%b out_valid=%b want 1/0", n, in_ready, out_valid); end
        end
        out_ready = 1'b0;
        sub = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [WIDTH:0] q[$];
        logic [WIDTH:0] e;
        logic           acc;
        int             sent = 0;
        int             got = 0;
        int             budget = 0;
        int             cyc = 0;
        int             last_acc = -1;
        out_ready = 1'b1;
        sub = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        in_valid = 1'b1;
        while (got < 6 && budget < 200) begin
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(model(a, b, cin, 1'b0));
                if (last_acc >= 0) begin
                    checks++; if (cyc - last_acc < NSLICE + 1) begin failures++; $display("FAIL b2b_overlap interval=%0d want>=%0d", cyc - last_acc, NSLICE + 1); end
                end
                last_acc = cyc;
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected_result sum=%h want none", sum);
                end else begin
                    e = q.pop_front();
                    if (sum !== e[WIDTH-1:0] || cout !== e[WIDTH]) begin failures++; $display("FAIL b2b%0d_result sum=%h cout=%b want %h/%b", got, sum, cout, e[WIDTH-1:0], e[WIDTH]); end
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++; budget++;
            if (acc) begin
                sent++;
                if (sent < 6) begin
                    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 6) begin failures++; $display("FAIL b2b_timeout results=%0d want=6", got); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nibble_serial_add_ctrl
`default_nettype wire
